memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage; consumes its control flags, funct_3, rs2 data, write register and result (ALU result or effective address).
- Loads and stores perform one access on a simple request/acknowledge data-memory port; other instructions pass result_data through.
- Produces write-back data for the write-back stage using the same prev_done/stall_prev and done_next/next_stall handshake used by all stages.

---
 rtl/memory_stage.sv | 214 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory access pipeline stage between execute and write-back
//
// Purpose: accepts one instruction at a time from execute. Non-memory instructions pass
// result_data through. Loads and stores make one access on a request/acknowledge port.
// Faulting loads and stores make no access. The finished result is held for write-back.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   prev_done / stall_prev    upstream handshake (execute -> this stage)
//   done_next / next_stall    downstream handshake (this stage -> write-back)
//   load, store, funct_3      instruction class, access width and signedness
//   register_2_data           store data
//   result_data(_valid)       ALU result or effective address
//   write_register(_valid)    destination register and its enable
//   mem_req/mem_write/mem_addr/mem_wdata/mem_wstrb   data-memory request, held until mem_ack
//   mem_ack/mem_rdata         single-cycle completion pulse with read word
//   wb_data/wb_register/wb_register_valid            write-back outputs
//   access_fault              misaligned address or illegal funct_3 on a load/store

module memory_stage #(
  parameter int ADDR_WIDTH              = 32,
  parameter int DATA_WIDTH              = 32,
  parameter int REGISTER_INDEXING_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               stall_prev,
  input  logic                               prev_done,
  input  logic                               next_stall,
  output logic                               done_next,
  input  logic                               load,
  input  logic                               store,
  input  logic [2:0]                         funct_3,
  input  logic [DATA_WIDTH-1:0]              register_2_data,
  input  logic [DATA_WIDTH-1:0]              result_data,
  input  logic                               result_data_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register,
  input  logic                               write_register_valid,
  output logic                               mem_req,
  output logic                               mem_write,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [3:0]                         mem_wstrb,
  input  logic                               mem_ack,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic [DATA_WIDTH-1:0]              wb_data,
  output logic [REGISTER_INDEXING_WIDTH-1:0] wb_register,
  output logic                               wb_register_valid,
  output logic                               access_fault
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0] state;

  // Captured at acceptance; needed again when the read word comes back.
  logic [2:0] funct_3_q;
  logic [1:0] addr_lsb_q;
  logic       write_register_valid_q;

  logic transfer_next;
  logic accept;

  assign done_next     = !rst && (state == S_HOLD);
  assign transfer_next = done_next && !next_stall;
  assign stall_prev    = rst || (state == S_ACCESS) || ((state == S_HOLD) && !transfer_next);
  // stall_prev is low only in IDLE or in HOLD while the held result leaves.
  // That lets a new instruction enter in the same cycle, with no bubble.
  assign accept        = prev_done && !stall_prev;

  // Decode of the incoming instruction.
  logic [1:0]            addr_lsb;
  logic                  is_mem;
  logic                  funct_illegal;
  logic                  misaligned;
  logic                  fault;
  logic [DATA_WIDTH-1:0] store_wdata;
  logic [3:0]            store_wstrb;

  assign addr_lsb = result_data[1:0];
  assign is_mem   = load || store;

  always_comb begin
    funct_illegal = 1'b0;
    misaligned    = 1'b0;
    if (load) begin
      funct_illegal = (funct_3 == 3'b011) || (funct_3[2:1] == 2'b11);
    end else if (store) begin
      funct_illegal = funct_3[2] || (funct_3[1:0] == 2'b11);
    end
    if (funct_3[1:0] == 2'b01) begin
      misaligned = addr_lsb[0];
    end else if (funct_3[1:0] == 2'b10) begin
      misaligned = (addr_lsb != 2'b00);
    end
    fault = is_mem && (funct_illegal || misaligned);
  end

  // Store data is replicated across every lane. The memory then writes only
  // the strobed bytes and ignores the address low bits.
  always_comb begin
    store_wdata = register_2_data;
    store_wstrb = 4'b1111;
    case (funct_3[1:0])
      2'b00: begin
        store_wdata = {4{register_2_data[7:0]}};
        store_wstrb = 4'b0001 << addr_lsb;
      end
      2'b01: begin
        store_wdata = {2{register_2_data[15:0]}};
        store_wstrb = addr_lsb[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_wdata = register_2_data;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction from the returned word.
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;

  always_comb begin
    case (addr_lsb_q)
      2'b00:   load_byte = mem_rdata[7:0];
      2'b01:   load_byte = mem_rdata[15:8];
      2'b10:   load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = addr_lsb_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct_3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // A request in flight is dropped here. A late mem_ack is ignored because
      // the state is no longer ACCESS.
      state                  <= S_IDLE;
      mem_req                <= 1'b0;
      mem_write              <= 1'b0;
      mem_addr               <= '0;
      mem_wdata              <= '0;
      mem_wstrb              <= 4'b0000;
      wb_data                <= '0;
      wb_register            <= '0;
      wb_register_valid      <= 1'b0;
      access_fault           <= 1'b0;
      funct_3_q              <= 3'b000;
      addr_lsb_q             <= 2'b00;
      write_register_valid_q <= 1'b0;
    end else begin
      case (state)
        S_ACCESS: begin
          if (mem_ack) begin
            state             <= S_HOLD;
            mem_req           <= 1'b0;
            wb_register_valid <= !mem_write && write_register_valid_q;
            if (!mem_write) begin
              wb_data <= load_data;
            end
          end
        end
        S_HOLD: begin
          if (transfer_next && !accept) begin
            state <= S_IDLE;
          end
        end
        default: ;
      endcase

      // accept is true only in IDLE or HOLD, so this never overrides ACCESS.
      if (accept) begin
        funct_3_q              <= funct_3;
        addr_lsb_q             <= addr_lsb;
        write_register_valid_q <= write_register_valid;
        wb_register            <= write_register;
        mem_write              <= store;
        mem_addr               <= {result_data[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata              <= store ? store_wdata : '0;
        mem_wstrb              <= store ? store_wstrb : 4'b0000;
        if (!is_mem) begin
          state             <= S_HOLD;
          mem_req           <= 1'b0;
          access_fault      <= 1'b0;
          wb_data           <= result_data_valid ? result_data : '0;
          wb_register_valid <= write_register_valid;
        end else if (fault) begin
          state             <= S_HOLD;
          mem_req           <= 1'b0;
          access_fault      <= 1'b1;
          wb_data           <= '0;
          wb_register_valid <= 1'b0;
        end else begin
          state             <= S_ACCESS;
          mem_req           <= 1'b1;
          access_fault      <= 1'b0;
          wb_data           <= '0;
          wb_register_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed self-checking bench for memory_stage

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_prev;
  logic        prev_done;
  logic        next_stall;
  logic        done_next;
  logic        load;
  logic        store;
  logic [2:0]  funct_3;
  logic [31:0] register_2_data;
  logic [31:0] result_data;
  logic        result_data_valid;
  logic [4:0]  write_register;
  logic        write_register_valid;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_register;
  logic        wb_register_valid;
  logic        access_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .stall_prev(stall_prev), .prev_done(prev_done),
    .next_stall(next_stall), .done_next(done_next), .load(load), .store(store),
    .funct_3(funct_3), .register_2_data(register_2_data), .result_data(result_data),
    .result_data_valid(result_data_valid), .write_register(write_register),
    .write_register_valid(write_register_valid), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_data(wb_data), .wb_register(wb_register),
    .wb_register_valid(wb_register_valid), .access_fault(access_fault)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] r2,
                         input logic [4:0] wr, input logic wrv);
    prev_done            = 1'b1;
    load                 = ld;
    store                = st;
    funct_3              = f3;
    result_data          = addr;
    register_2_data      = r2;
    write_register       = wr;
    write_register_valid = wrv;
    result_data_valid    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; prev_done = 1'b0; next_stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    load = 1'b0; store = 1'b0; funct_3 = 3'b000; register_2_data = '0; result_data = '0;
    result_data_valid = 1'b0; write_register = '0; write_register_valid = 1'b0;
    step(); step();
    n_cmp++; if (stall_prev !== 1'b1) begin n_err++; $display("FAIL reset_stall_prev: got %b want 1", stall_prev); end
    n_cmp++; if (done_next !== 1'b0) begin n_err++; $display("FAIL reset_done_next: got %b want 0", done_next); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (wb_register_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_register_valid); end
    n_cmp++; if (access_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", access_fault); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    n_cmp++; if (wb_register !== 5'd0) begin n_err++; $display("FAIL reset_wb_register: got %0d want 0", wb_register); end
    rst = 1'b0;
    #1;
    n_cmp++; if (stall_prev !== 1'b0) begin n_err++; $display("FAIL idle_stall_prev: got %b want 0", stall_prev); end
  endtask

  task automatic test_add();
    present(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    step();
    prev_done = 1'b0;
    n_cmp++; if (done_next !== 1'b1) begin n_err++; $display("FAIL add_done_next: got %b want 1", done_next); end
    n_cmp++; if (wb_data !== 32'h0000_1234) begin n_err++; $display("FAIL add_wb_data: got %h want 00001234", wb_data); end
    n_cmp++; if (wb_register !== 5'd5) begin n_err++; $display("FAIL add_wb_register: got %0d want 5", wb_register); end
    n_cmp++; if (wb_register_valid !== 1'b1) begin n_err++; $display("FAIL add_wb_valid: got %b want 1", wb_register_valid); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL add_mem_req: got %b want 0", mem_req); end
    step();
    n_cmp++; if (done_next !== 1'b0) begin n_err++; $display("FAIL add_return_idle: got %b want 0", done_next); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL add_mem_req_after: got %b want 0", mem_req); end
  endtask

  // Byte load at 0x103. The ack arrives on the third edge after mem_req rises.
  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data);
    present(1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
    step();
    prev_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL ld%0d_mem_req: got %b want 1", f3, mem_req); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL ld%0d_mem_write: got %b want 0", f3, mem_write); end
    n_cmp++; if (mem_addr !== 32'h0000_0100) begin n_err++; $display("FAIL ld%0d_mem_addr: got %h want 00000100", f3, mem_addr); end
    n_cmp++; if (mem_wstrb !== 4'b0000) begin n_err++; $display("FAIL ld%0d_mem_wstrb: got %b want 0000", f3, mem_wstrb); end
    n_cmp++; if (stall_prev !== 1'b1) begin n_err++; $display("FAIL ld%0d_stall_prev: got %b want 1", f3, stall_prev); end
    step();
    n_cmp++; if (mem_req !== 1'b1 || done_next !== 1'b0) begin n_err++; $display("FAIL ld%0d_wait: got req=%b done=%b want req=1 done=0", f3, mem_req, done_next); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ld%0d_req_drop: got %b want 0", f3, mem_req); end
    n_cmp++; if (done_next !== 1'b1) begin n_err++; $display("FAIL ld%0d_done_next: got %b want 1", f3, done_next); end
    n_cmp++; if (wb_data !== exp_data) begin n_err++; $display("FAIL ld%0d_wb_data: got %h want %h", f3, wb_data, exp_data); end
    n_cmp++; if (wb_register_valid !== 1'b1 || wb_register !== 5'd9) begin n_err++; $display("FAIL ld%0d_wb_reg: got v=%b r=%0d want v=1 r=9", f3, wb_register_valid, wb_register); end
    step();
  endtask

  task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] r2,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb);
    present(1'b0, 1'b1, f3, addr, r2, 5'd7, 1'b1);
    step();
    prev_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_write !== 1'b1) begin n_err++; $display("FAIL st%0d_req: got req=%b wr=%b want 1 1", f3, mem_req, mem_write); end
    n_cmp++; if (mem_addr !== exp_addr) begin n_err++; $display("FAIL st%0d_addr: got %h want %h", f3, mem_addr, exp_addr); end
    n_cmp++; if (mem_wdata !== exp_wdata) begin n_err++; $display("FAIL st%0d_wdata: got %h want %h", f3, mem_wdata, exp_wdata); end
    n_cmp++; if (mem_wstrb !== exp_wstrb) begin n_err++; $display("FAIL st%0d_wstrb: got %b want %b", f3, mem_wstrb, exp_wstrb); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (done_next !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL st%0d_done: got done=%b req=%b want 1 0", f3, done_next, mem_req); end
    n_cmp++; if (wb_register_valid !== 1'b0) begin n_err++; $display("FAIL st%0d_wb_valid: got %b want 0", f3, wb_register_valid); end
    step();
  endtask

  task automatic test_fault(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr);
    present(ld, st, f3, addr, 32'hCAFE_F00D, 5'd11, 1'b1);
    step();
    prev_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fault_%b%b%0d_mem_req: got %b want 0", ld, st, f3, mem_req); end
    n_cmp++; if (done_next !== 1'b1) begin n_err++; $display("FAIL fault_%b%b%0d_done: got %b want 1", ld, st, f3, done_next); end
    n_cmp++; if (access_fault !== 1'b1) begin n_err++; $display("FAIL fault_%b%b%0d_flag: got %b want 1", ld, st, f3, access_fault); end
    n_cmp++; if (wb_register_valid !== 1'b0) begin n_err++; $display("FAIL fault_%b%b%0d_wb_valid: got %b want 0", ld, st, f3, wb_register_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    present(1'b0, 1'b0, 3'b000, 32'h0000_AAAA, 32'h0, 5'd3, 1'b1);
    next_stall = 1'b1;
    step();
    // The next instruction waits upstream while write-back stalls.
    present(1'b0, 1'b0, 3'b000, 32'h0000_BBBB, 32'h0, 5'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (done_next !== 1'b1 || stall_prev !== 1'b1) begin n_err++; $display("FAIL bp_hold_%0d: got done=%b stall=%b want 1 1", i, done_next, stall_prev); end
      n_cmp++; if (wb_data !== 32'h0000_AAAA || wb_register !== 5'd3) begin n_err++; $display("FAIL bp_stable_%0d: got %h/%0d want 0000aaaa/3", i, wb_data, wb_register); end
      step();
    end
    next_stall = 1'b0;
    #1;
    n_cmp++; if (stall_prev !== 1'b0) begin n_err++; $display("FAIL bp_release_stall: got %b want 0", stall_prev); end
    step();
    prev_done = 1'b0;
    n_cmp++; if (done_next !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", done_next); end
    n_cmp++; if (wb_data !== 32'h0000_BBBB || wb_register !== 5'd4) begin n_err++; $display("FAIL b2b_data: got %h/%0d want 0000bbbb/4", wb_data, wb_register); end
    step();
    n_cmp++; if (done_next !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", done_next); end
  endtask

  task automatic test_reset_in_access();
    present(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd12, 1'b1);
    step();
    prev_done = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstacc_req_before: got %b want 1", mem_req); end
    rst = 1'b1;
    step();
    n_cmp++; if (mem_req !== 1'b0 || done_next !== 1'b0) begin n_err++; $display("FAIL rstacc_after_reset: got req=%b done=%b want 0 0", mem_req, done_next); end
    rst = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (done_next !== 1'b0 || mem_req !== 1'b0 || wb_register_valid !== 1'b0) begin n_err++; $display("FAIL rstacc_ack_ignored_%0d: got done=%b req=%b v=%b want 0 0 0", i, done_next, mem_req, wb_register_valid); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_byte(3'b000, 32'hFFFF_FF80);
    test_load_byte(3'b100, 32'h0000_0080);
    test_store(3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0000_0200, 32'hBEEF_BEEF, 4'b1100);
    test_store(3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010);
    test_store(3'b010, 32'h0000_0204, 32'h0BAD_CAFE, 32'h0000_0204, 32'h0BAD_CAFE, 4'b1111);
    test_fault(1'b1, 1'b0, 3'b010, 32'h0000_0001);
    test_fault(1'b0, 1'b1, 3'b011, 32'h0000_0000);
    test_fault(1'b1, 1'b0, 3'b001, 32'h0000_0003);
    test_back_to_back();
    test_reset_in_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
